regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised multi-port integer register file with a built-in write-pending scoreboard, for the ZeroCPU decode/writeback boundary.
- Provides NRD combinational read ports with same-cycle write-to-read forwarding and NWR synchronous write ports.
- Provides one issue port that marks a destination register busy until its writeback arrives.
- Register 0 is hard-wired to zero.

Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREG), register address width; derived, not overridden.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data.
- rd_busy  out  NRD  1 = operand not yet available; consumer must stall.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*XLEN  packed write data.
- iss_en  in  1  instruction issued with a destination register.
- iss_addr  in  AW  destination register of the issued instruction.
- busy_vec  out  NREG  current scoreboard bits, bit 0 always 0.
- busy_cnt  out  AW+1  number of set scoreboard bits (registered).

Behaviour:
- Reset (rst=1 at posedge):
  - All NREG registers become 0, all busy bits become 0, busy_cnt becomes 0.
  - Writes and issues are ignored during reset.
- While rst=1: rd_data is forced to 0 and rd_busy to 0 combinationally.
- Register 0:
  - Never written; its storage is either absent or constant 0.
  - A read of address 0 returns 0 with rd_busy=0.
  - Issue or write to address 0 has no effect.
- Read port k:
  - Purely combinational, zero latency.
  - If rd_en[k]=0: rd_data=0, rd_busy=0.
  - Else, if some wr_en[j]=1 with wr_addr[j]==rd_addr[k]!=0: forward wr_data[j]. If several ports match, the highest index j wins. rd_busy[k]=0.
  - Otherwise return the stored value, with rd_busy[k]=busy[rd_addr[k]].
- Write:
  - At posedge with wr_en[j]=1 and address nonzero, the register takes wr_data[j].
  - Same address on several write ports in one cycle: highest index wins.
  - Write is visible through storage from the next cycle.
- Scoreboard next-state, per register r≠0:
  - set = iss_en & iss_addr==r
  - clr = any wr_en[j] & wr_addr[j]==r
  - busy_next = set | (busy & ~clr)
  - Issue and writeback to the same register in the same cycle leaves busy=1, because the new producer takes precedence.
- Issue does not affect read data or the forwarding decision in the issue cycle; busy appears the following cycle.
- busy_cnt is a registered popcount of busy_next; it equals popcount(busy_vec) in every cycle.
- No overflow case exists: busy_cnt is bounded by NREG-1.

Decomposition:
- Shared package zerocpu_pkg holds XLEN and the default NREG, plus ZERO_64 and the reg-address typedef; both are reused by the decode and writeback stages.
- One natural sub-module, regfile_scoreboard: busy bit array, set/clear logic and popcount, parametrised by NREG, NWR and AW.
- Storage, forwarding and port unpacking stay in regfile_sb.

Test Plan:
- Reset then read: rst for 2 cycles; then rd_en=11, rd_addr={5,3} -> rd_data={0,0}, rd_busy=00, busy_cnt=0.
- Write then read: wr port0 writes x3=0x1234 in cycle n.
  - In cycle n, a read of x3 forwards 0x1234.
  - In cycle n+1, with wr_en=0, a read of x3 still returns 0x1234.
- Dual write conflict: wr0 writes x7=0xAA and wr1 writes x7=0xBB in the same cycle -> same-cycle read of x7 returns 0xBB; the stored value of x7 is 0xBB.
- x0 protection:
  - Write x0=0xFFFF and iss_addr=0 -> a read of x0 returns 0, rd_busy=0, busy_vec[0]=0.
- Scoreboard lifecycle:
  - Issue x9 -> next cycle busy_vec[9]=1, busy_cnt=1, and a read of x9 gives rd_busy=1.
  - Writeback x9=0x55 -> same-cycle read of x9 gives 0x55 with rd_busy=0; next cycle busy_vec[9]=0, busy_cnt=0.
- Simultaneous issue and writeback of x4, plus reset mid-operation:
  - Busy x4 receives a writeback and a new issue in the same cycle -> busy_vec[4] stays 1.
  - Then assert rst with x4 busy and x4=0x9 -> next cycle busy_vec=0 and a read of x4 returns 0.

Source files
------------

// File: rtl/zerocpu_pkg.sv
// Shared ZeroCPU definitions used by the decode and writeback stages.
package zerocpu_pkg;

  localparam int XLEN         = 64;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_AW       = $clog2(NREG_DEFAULT);

  localparam logic [63:0] ZERO_64 = 64'h0;

  // Architectural register index for the default register count.
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on issue,
// cleared on writeback, plus a registered count of set bits.
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [AW:0]       busy_cnt
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_next;

  // Next busy state: a new issue beats a writeback to the same register,
  // since the issued instruction is the newer producer. x0 never goes busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_en) set_vec[iss_addr] = 1'b1;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) clr_vec[wr_addr[j*AW +: AW]] = 1'b1;
    end
    busy_next    = set_vec | (busy_q & ~clr_vec);
    busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[r]};
    end
  end

  // Busy bits and their count are registered together so they always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_next;
      cnt_q  <= cnt_next;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write forwarding and a
// write-pending scoreboard. Register 0 always reads as zero and is never busy.
module regfile_sb #(
  parameter  int XLEN = zerocpu_pkg::XLEN,
  parameter  int NREG = zerocpu_pkg::NREG_DEFAULT,
  localparam int AW   = $clog2(NREG),
  parameter  int NRD  = 2,
  parameter  int NWR  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW:0]         busy_cnt
);

  import zerocpu_pkg::*;

  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   rd_a [NRD];
  logic [AW-1:0]   wr_a [NWR];
  logic [XLEN-1:0] wr_d [NWR];

  for (genvar k = 0; k < NRD; k++) begin : g_rd_unpack
    assign rd_a[k] = rd_addr[k*AW +: AW];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
    assign wr_a[j] = wr_addr[j*AW +: AW];
    assign wr_d[j] = wr_data[j*XLEN +: XLEN];
  end

  // Storage: ports are applied in ascending order so the highest-index
  // port wins an address collision. Writes to x0 are dropped, so its entry
  // stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= XLEN'(ZERO_64);
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_a[j] != '0)) regs[wr_a[j]] <= wr_d[j];
      end
    end
  end

  // Read ports: stored value and busy bit, overridden by any same-cycle
  // write to the address (highest port last). A forwarded operand is ready.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!rst && rd_en[k] && (rd_a[k] != '0)) begin
        rd_data[k*XLEN +: XLEN] = regs[rd_a[k]];
        rd_busy[k]              = busy_vec[rd_a[k]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_a[j] == rd_a[k])) begin
            rd_data[k*XLEN +: XLEN] = wr_d[j];
            rd_busy[k]              = 1'b0;
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table for the named scenarios, then
// randomized traffic checked against an array-based reference model.
module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREG-1:0]     busy_vec;
  logic [AW:0]         busy_cnt;

  regfile_sb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_mem [NREG];
  logic [NREG-1:0] m_busy;

  // Architectural read: x0/disabled/reset give zero; otherwise the newest
  // value, where a same-cycle write (highest port first) is newer than storage.
  task automatic model_read(input int k, output logic [XLEN-1:0] d, output logic b);
    logic [AW-1:0] a;
    a = rd_addr[k*AW +: AW];
    d = '0;
    b = 1'b0;
    if (!rst && rd_en[k] && a != 0) begin
      d = m_mem[a];
      b = m_busy[a];
      for (int j = NWR - 1; j >= 0; j--) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
          d = wr_data[j*XLEN +: XLEN];
          b = 1'b0;
          break;
        end
      end
    end
  endtask

  // End-of-cycle update: writes land in port order, writebacks retire
  // pending results, then the issued destination becomes pending.
  task automatic model_commit();
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_mem[r] = '0;
      m_busy = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
          m_mem[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compares the model's view against the DUT outputs (called at negedge).
  task automatic check_model(input bit chk_reg);
    logic [XLEN-1:0] d;
    logic            b;
    for (int k = 0; k < NRD; k++) begin
      model_read(k, d, b);
      exp_q.push_back(d);
      chk($sformatf("model_rd_busy%0d", k), XLEN'(rd_busy[k]), XLEN'(b));
    end
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("model_rd_data%0d", k), rd_data[k*XLEN +: XLEN], exp_q.pop_front());
    end
    if (chk_reg) begin
      chk("model_busy_vec", XLEN'(busy_vec), XLEN'(m_busy));
      chk("model_busy_cnt", XLEN'(busy_cnt), XLEN'($countones(m_busy)));
    end
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst;
    logic [1:0]      re;
    logic [AW-1:0]   ra0, ra1;
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            ie;
    logic [AW-1:0]   ia;
    logic [XLEN-1:0] e0, e1;
    logic [1:0]      eb;
    logic [AW:0]     ecnt;
    logic            chk_reg;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
    input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
    input logic [XLEN-1:0] wd0, input logic [XLEN-1:0] wd1,
    input logic ie, input logic [AW-1:0] ia,
    input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1,
    input logic [1:0] eb, input logic [AW:0] ecnt, input logic chk_reg);
    vec_t v;
    v.rst = r;  v.re = re;   v.ra0 = ra0; v.ra1 = ra1;
    v.we = we;  v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.ie = ie;  v.ia = ia;   v.e0 = e0;   v.e1 = e1;
    v.eb = eb;  v.ecnt = ecnt; v.chk_reg = chk_reg;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst      = v.rst;
    rd_en    = v.re;
    rd_addr  = {v.ra1, v.ra0};
    wr_en    = v.we;
    wr_addr  = {v.wa1, v.wa0};
    wr_data  = {v.wd1, v.wd0};
    iss_en   = v.ie;
    iss_addr = v.ia;
  endtask

  task automatic drive_random();
    rst     = ($urandom_range(0, 39) == 0);
    rd_en   = 2'($urandom_range(0, 3));
    rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    wr_en   = 2'($urandom_range(0, 3));
    wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    if ($urandom_range(0, 7) == 0) wr_addr[4:0] = 5'($urandom_range(0, NREG - 1));
    wr_data  = {$urandom, $urandom, $urandom, $urandom};
    iss_en   = ($urandom_range(0, 2) == 0);
    iss_addr = 5'($urandom_range(0, 7));
  endtask

  vec_t tab [16];

  initial begin
    for (int r = 0; r < NREG; r++) m_mem[r] = '0;
    m_busy = '0;

    //             rst re  ra0 ra1 we    wa0 wa1 wd0      wd1    ie ia e0       e1       eb     cnt chk
    tab[0]  = mk(1, 0,  0,  0,  0,     0,  0,  0,       0,     0, 0, 0,       0,       2'b00, 0,  0);
    tab[1]  = mk(1, 0,  0,  0,  0,     0,  0,  0,       0,     0, 0, 0,       0,       2'b00, 0,  1);
    tab[2]  = mk(0, 3,  3,  5,  0,     0,  0,  0,       0,     0, 0, 0,       0,       2'b00, 0,  1);
    tab[3]  = mk(0, 3,  3,  5,  2'b01, 3,  0,  'h1234, 0,     0, 0, 'h1234,  0,       2'b00, 0,  1);
    tab[4]  = mk(0, 3,  3,  5,  0,     0,  0,  0,       0,     0, 0, 'h1234,  0,       2'b00, 0,  1);
    tab[5]  = mk(0, 3,  7,  3,  2'b11, 7,  7,  'hAA,    'hBB,  0, 0, 'hBB,    'h1234,  2'b00, 0,  1);
    tab[6]  = mk(0, 3,  7,  0,  2'b01, 0,  0,  'hFFFF,  0,     1, 0, 'hBB,    0,       2'b00, 0,  1);
    tab[7]  = mk(0, 3,  9,  0,  0,     0,  0,  0,       0,     1, 9, 0,       0,       2'b00, 0,  1);
    tab[8]  = mk(0, 3,  9,  0,  0,     0,  0,  0,       0,     0, 0, 0,       0,       2'b01, 1,  1);
    tab[9]  = mk(0, 3,  9,  0,  2'b01, 9,  0,  'h55,    0,     0, 0, 'h55,    0,       2'b00, 1,  1);
    tab[10] = mk(0, 3,  9,  0,  0,     0,  0,  0,       0,     0, 0, 'h55,    0,       2'b00, 0,  1);
    tab[11] = mk(0, 3,  4,  9,  2'b10, 0,  4,  0,       'h9,   1, 4, 'h9,     'h55,    2'b00, 0,  1);
    tab[12] = mk(0, 3,  4,  9,  2'b01, 4,  0,  'h9,     0,     1, 4, 'h9,     'h55,    2'b00, 1,  1);
    tab[13] = mk(0, 3,  4,  9,  0,     0,  0,  0,       0,     0, 0, 'h9,     'h55,    2'b01, 1,  1);
    tab[14] = mk(1, 3,  4,  9,  2'b01, 4,  0,  'hDEAD,  0,     1, 5, 0,       0,       2'b00, 1,  1);
    tab[15] = mk(0, 3,  4,  5,  0,     0,  0,  0,       0,     0, 0, 0,       0,       2'b00, 0,  1);

    // Directed phase: each row is one clock cycle.
    for (int i = 0; i < 16; i++) begin
      drive(tab[i]);
      @(negedge clk);
      exp_q.push_back(tab[i].e0);
      exp_q.push_back(tab[i].e1);
      chk($sformatf("row%0d_rd_data0", i), rd_data[XLEN-1:0], exp_q.pop_front());
      chk($sformatf("row%0d_rd_data1", i), rd_data[2*XLEN-1:XLEN], exp_q.pop_front());
      chk($sformatf("row%0d_rd_busy", i), XLEN'(rd_busy), XLEN'(tab[i].eb));
      if (tab[i].chk_reg) begin
        chk($sformatf("row%0d_busy_cnt", i), XLEN'(busy_cnt), XLEN'(tab[i].ecnt));
        chk($sformatf("row%0d_busy_vec0", i), XLEN'(busy_vec[0]), '0);
        check_model(1'b1);
      end
      end_cycle();
    end

    // Randomized phase against the reference model.
    for (int c = 0; c < 600; c++) begin
      drive_random();
      @(negedge clk);
      check_model(1'b1);
      end_cycle();
    end

    // Final report.
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
